// File: rtl/rformat_exec_ctrl.sv
// rformat_exec_ctrl: four-state R-format sequencer (IDLE, READ, EXEC, WB) driving register-file reads and one write-back.
module rformat_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rs_addr,
  output logic [ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] result
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;
  logic [1:0]        state;
  logic [5:0]        op_q;
  logic [5:0]        fn_q;
  logic [4:0]        sh_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic [DATA_W-1:0] alu_res;
  logic              alu_err;
  assign instr_ready = (state == IDLE) & ~reset;
  assign sum         = op_a + op_b;
  assign diff        = op_a - op_b;
  assign add_ovf     = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
  assign sub_ovf     = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
  // Illegal encodings yield a zero result; overflow keeps the wrapped value.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (fn_q)
      6'h20: begin alu_res = sum;  alu_err = add_ovf; end
      6'h21: alu_res = sum;
      6'h22: begin alu_res = diff; alu_err = sub_ovf; end
      6'h23: alu_res = diff;
      6'h24: alu_res = op_a & op_b;
      6'h25: alu_res = op_a | op_b;
      6'h26: alu_res = op_a ^ op_b;
      6'h27: alu_res = ~(op_a | op_b);
      6'h2A: alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      6'h2B: alu_res = {{(DATA_W-1){1'b0}}, op_a < op_b};
      6'h00: alu_res = op_b << sh_q;
      6'h02: alu_res = op_b >> sh_q;
      6'h03: alu_res = $signed(op_b) >>> sh_q;
      default: alu_err = 1'b1;
    endcase
    if (op_q != 6'd0) begin
      alu_res = '0;
      alu_err = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      sh_q    <= '0;
      rd_q    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      rs_addr <= '0;
      rt_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      result  <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (instr_valid) begin
          op_q    <= instr[31:26];
          rs_addr <= instr[25:21];
          rt_addr <= instr[20:16];
          rd_q    <= instr[15:11];
          sh_q    <= instr[10:6];
          fn_q    <= instr[5:0];
          state   <= READ;
        end
        READ: begin
          op_a  <= rs_data;
          op_b  <= rt_data;
          state <= EXEC;
        end
        EXEC: begin
          result  <= alu_res;
          wr_data <= alu_res;
          wr_addr <= rd_q;
          error   <= alu_err;
          wr_en   <= ~alu_err && (rd_q != '0);
          done    <= 1'b1;
          state   <= WB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rformat_exec_ctrl.sv
// tb_rformat_exec_ctrl: directed and random R-format instructions checked against an arithmetic reference model.
module tb_rformat_exec_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic        error;
  logic [31:0] result;
  logic [31:0] rf [32];
  int tests = 0;
  int fails = 0;

  rformat_exec_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .done(done), .error(error), .result(result)
  );

  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int rd, input int sh, input int fn);
    enc = {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  // Returns {error, write_enable, result} from the instruction rules using wide signed arithmetic.
  function automatic logic [33:0] model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    longint s;
    logic signed [31:0] sb;
    logic [31:0] res;
    logic err;
    int sh;
    sb  = b;
    sh  = int'(ins[10:6]);
    err = 0;
    res = 0;
    case (ins[5:0])
      6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); res = s[31:0]; err = s != longint'(int'(s)); end
      6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); res = s[31:0]; err = s != longint'(int'(s)); end
      6'h21: res = a + b;
      6'h23: res = a - b;
      6'h24: res = a & b;
      6'h25: res = a | b;
      6'h26: res = a ^ b;
      6'h27: res = ~(a | b);
      6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: res = (a < b) ? 32'd1 : 32'd0;
      6'h00: res = b << sh;
      6'h02: res = b >> sh;
      6'h03: res = sb >>> sh;
      default: err = 1;
    endcase
    if (ins[31:26] != 0) begin
      err = 1;
      res = 0;
    end
    model = {err, !err && ins[15:11] != 0, res};
  endfunction

  // Issues one instruction at a negedge in IDLE and follows it through WB; returns at the k+4 negedge.
  task automatic run(input logic [31:0] ins, input string nm, input bit hold);
    logic [33:0] m;
    m = model(ins, rf[ins[25:21]], rf[ins[20:16]]);
    tests++;
    if (instr_ready !== 1'b1) begin fails++; $display("FAIL %s idle_ready got %b want 1", nm, instr_ready); end
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
    instr = $urandom;
    tests++;
    if ({instr_ready, rs_addr, rt_addr, done, wr_en} !== {1'b0, ins[25:21], ins[20:16], 2'b00})
      begin fails++; $display("FAIL %s read got rdy=%b rs=%0d rt=%0d done=%b we=%b want rdy=0 rs=%0d rt=%0d done=0 we=0", nm, instr_ready, rs_addr, rt_addr, done, wr_en, ins[25:21], ins[20:16]); end
    @(negedge clk);
    tests++;
    if ({instr_ready, done, wr_en} !== 3'b000) begin fails++; $display("FAIL %s exec got rdy=%b done=%b we=%b want 000", nm, instr_ready, done, wr_en); end
    @(negedge clk);
    tests++;
    if ({instr_ready, done, error, wr_en} !== {2'b01, m[33], m[32]})
      begin fails++; $display("FAIL %s wb got rdy=%b done=%b err=%b we=%b want rdy=0 done=1 err=%b we=%b", nm, instr_ready, done, error, wr_en, m[33], m[32]); end
    tests++;
    if (result !== m[31:0]) begin fails++; $display("FAIL %s result got %h want %h", nm, result, m[31:0]); end
    if (m[32]) begin
      tests++;
      if ({wr_addr, wr_data} !== {ins[15:11], m[31:0]}) begin fails++; $display("FAIL %s wb_port got addr=%0d data=%h want addr=%0d data=%h", nm, wr_addr, wr_data, ins[15:11], m[31:0]); end
    end
    @(negedge clk);
    tests++;
    if ({instr_ready, done, wr_en} !== 3'b100) begin fails++; $display("FAIL %s after_wb got rdy=%b done=%b we=%b want 100", nm, instr_ready, done, wr_en); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 0;
    @(negedge clk);
    tests++;
    if ({instr_ready, rs_addr, rt_addr, wr_addr, wr_data, wr_en, done, error, result} !== 0)
      begin fails++; $display("FAIL reset_outputs got rdy=%b rs=%0d rt=%0d wa=%0d wd=%h we=%b done=%b err=%b res=%h want all 0", instr_ready, rs_addr, rt_addr, wr_addr, wr_data, wr_en, done, error, result); end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b want 1", instr_ready); end
  endtask

  task automatic test_add;
    rf[1] = 5; rf[2] = 7;
    run(32'h00221820, "add", 0);
    tests++;
    if (result !== 32'd12) begin fails++; $display("FAIL add_value got %h want 0000000c", result); end
    rf[1] = 32'h7FFFFFFF; rf[2] = 1;
    run(enc(0, 1, 2, 3, 0, 'h20), "add_ovf", 0);
    tests++;
    if (result !== 32'h80000000) begin fails++; $display("FAIL add_ovf_value got %h want 80000000", result); end
    run(enc(0, 1, 2, 3, 0, 'h21), "addu_wrap", 0);
    rf[1] = 32'h80000000; rf[2] = 1;
    run(enc(0, 1, 2, 11, 0, 'h22), "sub_ovf", 0);
  endtask

  task automatic test_compare;
    rf[4] = 32'hFFFFFFFF; rf[5] = 1;
    run(enc(0, 4, 5, 6, 0, 'h2A), "slt", 0);
    tests++;
    if (result !== 32'd1) begin fails++; $display("FAIL slt_value got %h want 00000001", result); end
    run(enc(0, 4, 5, 7, 0, 'h2B), "sltu", 0);
    tests++;
    if (result !== 32'd0) begin fails++; $display("FAIL sltu_value got %h want 00000000", result); end
  endtask

  task automatic test_shift;
    rf[2] = 32'h80000000;
    run(enc(0, 0, 2, 8, 4, 'h03), "sra", 0);
    tests++;
    if (result !== 32'hF8000000) begin fails++; $display("FAIL sra_value got %h want f8000000", result); end
    run(enc(0, 0, 2, 9, 4, 'h02), "srl", 0);
    tests++;
    if (result !== 32'h08000000) begin fails++; $display("FAIL srl_value got %h want 08000000", result); end
    run(enc(0, 0, 2, 10, 4, 'h00), "sll", 0);
  endtask

  task automatic test_illegal;
    rf[1] = 3; rf[2] = 4;
    run(enc(8, 1, 2, 3, 0, 'h20), "bad_op", 0);
    run(enc(0, 1, 2, 3, 0, 'h3F), "bad_funct", 0);
    run(enc(0, 1, 2, 0, 0, 'h20), "rd_zero", 0);
  endtask

  task automatic test_back_to_back;
    rf[12] = 32'h0000F0F0; rf[13] = 32'h00FF00FF;
    run(enc(0, 12, 13, 14, 0, 'h26), "b2b_first", 1);
    run(enc(0, 13, 12, 15, 0, 'h27), "b2b_second", 1);
    run(enc(0, 12, 12, 16, 0, 'h24), "b2b_third", 0);
  endtask

  task automatic test_reset_mid;
    bit seen;
    rf[1] = 9; rf[2] = 1;
    instr = enc(0, 1, 2, 3, 0, 'h21);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({instr_ready, rs_addr, rt_addr, wr_addr, wr_data, wr_en, done, error, result} !== 0)
      begin fails++; $display("FAIL mid_reset_outputs got rdy=%b rs=%0d rt=%0d wa=%0d wd=%h we=%b done=%b err=%b res=%h want all 0", instr_ready, rs_addr, rt_addr, wr_addr, wr_data, wr_en, done, error, result); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (instr_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_ready got %b want 1", instr_ready); end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || wr_en) seen = 1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL mid_reset_no_retire got a done/wr_en pulse want none"); end
  endtask

  task automatic test_random;
    int fns[14] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h00, 'h02, 'h03, 'h11};
    logic [31:0] edge_vals[4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] ins;
    for (int i = 0; i < 40; i++) begin
      ins = enc(($urandom_range(0, 9) == 0) ? 8 : 0, $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31), fns[$urandom_range(0, 13)]);
      rf[ins[25:21]] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      rf[ins[20:16]] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      run(ins, "random", $urandom_range(0, 1) == 1 && i != 39);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 0;
    test_reset;
    test_add;
    test_compare;
    test_shift;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
